// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with single-beat line refill and flush.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_dm #(
    parameter int NLINES    = 4,
    parameter int LINE_BITS = 128,
    parameter int XLEN      = 32,
    parameter int ILEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req_valid,
    output logic                 cpu_req_ready,
    input  logic [XLEN-1:0]      cpu_req_addr,
    output logic                 cpu_rsp_valid,
    output logic [ILEN-1:0]      cpu_rsp_instr,
    input  logic                 flush,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [XLEN-1:0]      mem_req_addr,
    input  logic                 mem_rsp_valid,
    input  logic [LINE_BITS-1:0] mem_rsp_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [XLEN-1:0]      stat_hits,
    output logic [XLEN-1:0]      stat_misses
`endif
);

    // state     | meaning
    // IDLE      | ready for a new fetch
    // LOOKUP    | tag compare on captured address; hit responds this cycle
    // MISS_REQ  | line refill request presented to memory
    // MISS_WAIT | waiting for the refill line; forwards requested word

    localparam int OFF  = $clog2(LINE_BITS / 8);
    localparam int IDX  = $clog2(NLINES);
    localparam int TAG  = XLEN - IDX - OFF;
    localparam int WSEL = $clog2(LINE_BITS / ILEN);
    localparam int NWORDS = LINE_BITS / ILEN;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT} state_t;

    state_t                 state, state_d;
    logic [XLEN-1:0]        addr_q;
    logic [NLINES-1:0]      valid_q;
    logic [TAG-1:0]         tag_arr  [NLINES];
    logic [LINE_BITS-1:0]   data_arr [NLINES];
    logic [ILEN-1:0]        instr_q;

    logic [TAG-1:0]         tag_q;
    logic [IDX-1:0]         idx_q;
    logic [WSEL-1:0]        word_q;
    logic                   hit;
    logic                   accept;
    logic                   refill;
    logic [LINE_BITS-1:0]   src_line;
    logic [ILEN-1:0]        sel_word;
    logic                   unused_addr_bits;

    assign tag_q  = addr_q[XLEN-1 -: TAG];
    assign idx_q  = addr_q[OFF +: IDX];
    assign word_q = addr_q[OFF-1 -: WSEL];
    assign unused_addr_bits = ^addr_q[1:0];

    // A flush in the lookup cycle must not let stale contents hit
    assign hit    = valid_q[idx_q] && (tag_arr[idx_q] == tag_q) && !flush;
    assign accept = cpu_req_valid && cpu_req_ready;
    assign refill = (state == MISS_WAIT) && mem_rsp_valid;

    assign src_line = (state == MISS_WAIT) ? mem_rsp_data : data_arr[idx_q];

    always_comb begin
        sel_word = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (word_q == w[WSEL-1:0]) sel_word = src_line[w*ILEN +: ILEN];
        end
    end

    always_comb begin
        state_d       = state;
        cpu_req_ready = 1'b0;
        cpu_rsp_valid = 1'b0;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_rsp_valid = 1'b1;
                    cpu_req_ready = 1'b1;
                    state_d       = cpu_req_valid ? LOOKUP : IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_rsp_valid) begin
                    cpu_rsp_valid = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_rsp_instr = cpu_rsp_valid ? sel_word : instr_q;
    assign mem_req_addr  = {addr_q[XLEN-1:OFF], {OFF{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            valid_q <= '0;
            instr_q <= '0;
        end else begin
            state <= state_d;
            if (accept) addr_q <= cpu_req_addr;
            if (cpu_rsp_valid) instr_q <= sel_word;
            // Flush wins over a coincident refill: data is forwarded but the line stays invalid
            if (flush) valid_q <= '0;
            else if (refill) valid_q[idx_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (refill) begin
            tag_arr[idx_q]  <= tag_q;
            data_arr[idx_q] <= mem_rsp_data;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state == LOOKUP) begin
            if (hit) stat_hits   <= stat_hits + 1'b1;
            else     stat_misses <= stat_misses + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, back-to-back hits, conflict, flush, reset mid-refill.
// Stat counters are checked when ICACHE_STATS_EN is defined.
module tb_icache_dm;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req_valid;
    logic         cpu_req_ready;
    logic [31:0]  cpu_req_addr;
    logic         cpu_rsp_valid;
    logic [31:0]  cpu_rsp_instr;
    logic         flush;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid;
    logic [127:0] mem_rsp_data;
`ifdef ICACHE_STATS_EN
    logic [31:0]  stat_hits;
    logic [31:0]  stat_misses;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] LINE_A = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
    localparam logic [127:0] LINE_B = 128'h11114444_11113333_11112222_11111111;
    localparam logic [127:0] LINE_C = 128'h2222DDDD_2222CCCC_2222BBBB_2222AAAA;

    always #5 clk = ~clk;

    icache_dm dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_instr (cpu_rsp_instr),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses)
`endif
    );

    task automatic test_reset();
        rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_addr = '0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        n_vec++;
        if ({cpu_req_ready, cpu_rsp_valid, mem_req_valid} !== 3'b100) begin
            n_err++; $display("FAIL reset_ctrl got ready/rsp/memreq=%b exp 100", {cpu_req_ready, cpu_rsp_valid, mem_req_valid});
        end
        n_vec++;
        if (cpu_rsp_instr !== 32'h0 || mem_req_addr !== 32'h0) begin
            n_err++; $display("FAIL reset_data got instr=%h mem_addr=%h exp 0/0", cpu_rsp_instr, mem_req_addr);
        end
    endtask

    // Full miss sequence: one cycle of mem_req_ready low, then `lat` cycles in MISS_WAIT
    task automatic do_miss(input logic [31:0] addr, input logic [127:0] line, input logic [31:0] exp,
                           input logic flush_lookup, input logic flush_rsp, input int lat);
        logic [31:0] line_addr;
        line_addr = {addr[31:4], 4'h0};
        @(negedge clk);
        flush = 1'b0; cpu_req_valid = 1'b1; cpu_req_addr = addr; #1;
        n_vec++;
        if (cpu_req_ready !== 1'b1) begin
            n_err++; $display("FAIL miss_accept addr=%h got ready=%b exp 1", addr, cpu_req_ready);
        end
        @(negedge clk);
        cpu_req_valid = 1'b0; flush = flush_lookup; #1;
        n_vec++;
        if ({cpu_rsp_valid, cpu_req_ready, mem_req_valid} !== 3'b000) begin
            n_err++; $display("FAIL miss_lookup addr=%h got rsp/ready/memreq=%b exp 000", addr, {cpu_rsp_valid, cpu_req_ready, mem_req_valid});
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            flush = 1'b0; mem_req_ready = (c == 1); #1;
            n_vec++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== line_addr || cpu_req_ready !== 1'b0) begin
                n_err++; $display("FAIL miss_memreq addr=%h c=%0d got v=%b a=%h rdy=%b exp 1 %h 0", addr, c, mem_req_valid, mem_req_addr, cpu_req_ready, line_addr);
            end
        end
        for (int c = 0; c < lat - 1; c++) begin
            @(negedge clk);
            mem_req_ready = 1'b0; #1;
            n_vec++;
            if ({mem_req_valid, cpu_rsp_valid, cpu_req_ready} !== 3'b000) begin
                n_err++; $display("FAIL miss_wait addr=%h got memreq/rsp/ready=%b exp 000", addr, {mem_req_valid, cpu_rsp_valid, cpu_req_ready});
            end
        end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = line; flush = flush_rsp; #1;
        n_vec++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_instr !== exp || cpu_req_ready !== 1'b0) begin
            n_err++; $display("FAIL miss_rsp addr=%h got v=%b instr=%h rdy=%b exp 1 %h 0", addr, cpu_rsp_valid, cpu_rsp_instr, cpu_req_ready, exp);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; flush = 1'b0; #1;
        n_vec++;
        if (cpu_rsp_valid !== 1'b0 || cpu_rsp_instr !== exp || cpu_req_ready !== 1'b1) begin
            n_err++; $display("FAIL miss_hold addr=%h got v=%b instr=%h rdy=%b exp 0 %h 1", addr, cpu_rsp_valid, cpu_rsp_instr, cpu_req_ready, exp);
        end
    endtask

    task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_addr = addr; #1;
        @(negedge clk);
        cpu_req_valid = 1'b0; #1;
        n_vec++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_instr !== exp || mem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL hit addr=%h got v=%b instr=%h memreq=%b exp 1 %h 0", addr, cpu_rsp_valid, cpu_rsp_instr, mem_req_valid, exp);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_cold_miss();
        do_miss(32'h1000, LINE_A, 32'h0000AAAA, 1'b0, 1'b0, 3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        addrs = '{32'h1004, 32'h1008, 32'h100C};
        exps  = '{32'h0000BBBB, 32'h0000CCCC, 32'h0000DDDD};
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_addr = addrs[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) cpu_req_addr = addrs[i+1];
            else cpu_req_valid = 1'b0;
            #1;
            n_vec++;
            if (cpu_rsp_valid !== 1'b1 || cpu_rsp_instr !== exps[i] || cpu_req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
                n_err++; $display("FAIL b2b_hit%0d got v=%b instr=%h rdy=%b memreq=%b exp 1 %h 1 0", i, cpu_rsp_valid, cpu_rsp_instr, cpu_req_ready, mem_req_valid, exps[i]);
            end
        end
        @(negedge clk); #1;
        n_vec++;
        if (cpu_rsp_valid !== 1'b0 || cpu_rsp_instr !== 32'h0000DDDD) begin
            n_err++; $display("FAIL b2b_idle got v=%b instr=%h exp 0 0000dddd", cpu_rsp_valid, cpu_rsp_instr);
        end
    endtask

    task automatic test_conflict();
        do_miss(32'h1040, LINE_B, 32'h11111111, 1'b0, 1'b0, 2);
        do_miss(32'h1000, LINE_A, 32'h0000AAAA, 1'b0, 1'b0, 1);
        do_hit(32'h1008, 32'h0000CCCC);
    endtask

    task automatic test_flush();
        do_miss(32'h2000, LINE_C, 32'h2222AAAA, 1'b0, 1'b1, 3);
        do_miss(32'h2000, LINE_C, 32'h2222AAAA, 1'b0, 1'b0, 1);
        do_miss(32'h2004, LINE_C, 32'h2222BBBB, 1'b1, 1'b0, 2);
        do_hit(32'h200C, 32'h2222DDDD);
    endtask

    task automatic test_stats(input logic [31:0] exp_hits, input logic [31:0] exp_misses);
`ifdef ICACHE_STATS_EN
        n_vec++;
        if (stat_hits !== exp_hits || stat_misses !== exp_misses) begin
            n_err++; $display("FAIL stats got hits=%0d misses=%0d exp %0d %0d", stat_hits, stat_misses, exp_hits, exp_misses);
        end
`else
        if (exp_hits == exp_misses + 32'hFFFF_FFFF) $display("stats not built");
`endif
    endtask

    task automatic test_reset_mid_refill();
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h3000;
        @(negedge clk);
        cpu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_req_ready = 1'b0; #1;
        n_vec++;
        if (mem_req_valid !== 1'b0 || cpu_req_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_pre got memreq=%b rdy=%b exp 0 0", mem_req_valid, cpu_req_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = LINE_C; #1;
        n_vec++;
        if ({cpu_req_ready, cpu_rsp_valid, mem_req_valid} !== 3'b100 || cpu_rsp_instr !== 32'h0 || mem_req_addr !== 32'h0) begin
            n_err++; $display("FAIL rst_mid got rdy/rsp/memreq=%b instr=%h addr=%h exp 100 0 0", {cpu_req_ready, cpu_rsp_valid, mem_req_valid}, cpu_rsp_instr, mem_req_addr);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; #1;
        n_vec++;
        if (cpu_rsp_valid !== 1'b0 || cpu_req_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_late_rsp got rsp=%b rdy=%b exp 0 1", cpu_rsp_valid, cpu_req_ready);
        end
        test_stats(32'd0, 32'd0);
        do_miss(32'h1000, LINE_A, 32'h0000AAAA, 1'b0, 1'b0, 1);
        test_stats(32'd0, 32'd1);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_flush();
        test_stats(32'd5, 32'd6);
        test_reset_mid_refill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
